// File: rtl/complex_alu_pkg.sv
// complex_alu_pkg: opcodes, per-lane DSP mode encodings
// and the opcode-to-lane-mode decoder shared by the ALU control path.
package complex_alu_pkg;

  localparam int LANES         = 4;
  localparam int ALUMODE_WIDTH = 4;
  localparam int INMODE_WIDTH  = 5;
  localparam int OPMODE_WIDTH  = 7;
  localparam int DATA_WIDTH    = 16;
  localparam int WORD_WIDTH    = 2 * DATA_WIDTH;
  localparam int OP_WIDTH      = 3;

  localparam logic [OP_WIDTH-1:0] OP_CMUL   = 3'b100;
  localparam logic [OP_WIDTH-1:0] OP_MULADD = 3'b101;
  localparam logic [OP_WIDTH-1:0] OP_MULSUB = 3'b110;

  // P = Z + X*Y and P = Z - X*Y
  localparam logic [ALUMODE_WIDTH-1:0] ALUMODE_ADD = 4'b0000;
  localparam logic [ALUMODE_WIDTH-1:0] ALUMODE_SUB = 4'b0011;

  // P = A*B and P = C + A*B
  localparam logic [OPMODE_WIDTH-1:0] OPMODE_AB  = 7'b0000101;
  localparam logic [OPMODE_WIDTH-1:0] OPMODE_CAB = 7'b0110101;

  localparam logic [INMODE_WIDTH-1:0] INMODE_AB = 5'b00000;

  typedef logic [LANES*ALUMODE_WIDTH-1:0] alumode_t;
  typedef logic [LANES*INMODE_WIDTH-1:0]  inmode_t;
  typedef logic [LANES*OPMODE_WIDTH-1:0]  opmode_t;
  typedef logic [WORD_WIDTH-1:0]          word_t;

  // Lane 1 lives in the MSB slice of every packed word.
  typedef struct packed {
    alumode_t alumode;
    inmode_t  inmode;
    opmode_t  opmode;
  } lane_modes_t;

  // One registered ALU launch: opcode, lane modes, operands.
  typedef struct packed {
    logic [OP_WIDTH-1:0] opcode;
    lane_modes_t         modes;
    word_t               din_1;
    word_t               din_2;
    word_t               din_3;
  } alu_issue_t;

  function automatic logic op_legal(
    input logic [OP_WIDTH-1:0] op
  );
    return (op == OP_CMUL) ||
           (op == OP_MULADD) ||
           (op == OP_MULSUB);
  endfunction

  // Lanes 1/3 form the real-part accumulate path,
  // lanes 2/4 are plain products in every opcode.
  function automatic lane_modes_t decode_modes(
    input logic [OP_WIDTH-1:0] op
  );
    lane_modes_t m;
    m.inmode  = {LANES{INMODE_AB}};
    m.alumode = {LANES{ALUMODE_ADD}};
    m.opmode  = {LANES{OPMODE_AB}};
    unique case (1'b1)
      op == OP_MULADD: begin
        m.opmode = {OPMODE_CAB, OPMODE_AB,
                    OPMODE_CAB, OPMODE_AB};
      end
      op == OP_MULSUB: begin
        m.opmode  = {OPMODE_CAB, OPMODE_AB,
                     OPMODE_CAB, OPMODE_AB};
        m.alumode = {ALUMODE_SUB, ALUMODE_ADD,
                     ALUMODE_SUB, ALUMODE_ADD};
      end
      default: begin
        m.opmode = {LANES{OPMODE_AB}};
      end
    endcase
    return m;
  endfunction

endpackage

// File: rtl/complex_alu_ctrl_res_fifo.sv
// res_fifo: synchronous first-word-fall-through FIFO
// with an occupancy count for credit accounting.
module res_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       data_i,
  input  logic                   pop_i,
  output logic                   valid_o,
  output logic [WIDTH-1:0]       data_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [CW-1:0]    cnt_q;
  logic             do_pop;

  assign valid_o = (cnt_q != '0);
  assign do_pop  = pop_i && valid_o;
  assign data_o  = mem_q[rd_q];
  assign count_o = cnt_q;

  // Pointers wrap for free because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + AW'(1);
      if (do_pop) rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + CW'(push_i) - CW'(do_pop);
    end
  end

  // Storage is cleared on reset so the head reads zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push_i) begin
      mem_q[wr_q] <= data_i;
    end
  end

  // Credits upstream must keep a full FIFO from being pushed.
  a_no_overflow: assert property (
    @(posedge clk) disable iff (rst)
    !(push_i && !do_pop && cnt_q == CW'(DEPTH))
  );

endmodule

// File: rtl/complex_alu_ctrl.sv
// complex_alu_ctrl: issue/writeback control around the
// 4-DSP complex ALU with credit-based result backpressure.
module complex_alu_ctrl
  import complex_alu_pkg::*;
#(
  parameter int ALU_LAT   = 4,
  parameter int RES_DEPTH = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [OP_WIDTH-1:0]             in_opcode,
  input  logic [WORD_WIDTH-1:0]           in_din_1,
  input  logic [WORD_WIDTH-1:0]           in_din_2,
  input  logic [WORD_WIDTH-1:0]           in_din_3,
  output logic [OP_WIDTH-1:0]             alu_opcode,
  output logic [LANES*ALUMODE_WIDTH-1:0]  alu_alumode,
  output logic [LANES*INMODE_WIDTH-1:0]   alu_inmode,
  output logic [LANES*OPMODE_WIDTH-1:0]   alu_opmode,
  output logic [LANES-1:0]                alu_cea2,
  output logic [LANES-1:0]                alu_ceb2,
  output logic [LANES-1:0]                alu_usemult,
  output logic [WORD_WIDTH-1:0]           alu_din_1,
  output logic [WORD_WIDTH-1:0]           alu_din_2,
  output logic [WORD_WIDTH-1:0]           alu_din_3,
  input  logic [WORD_WIDTH-1:0]           alu_dout,
  output logic                            res_valid,
  input  logic                            res_ready,
  output logic [WORD_WIDTH-1:0]           res_data,
  output logic                            err_illegal
);

  localparam int CW = $clog2(RES_DEPTH) + 1;

  logic             rst_q;
  logic             issue_q;
  logic             err_q;
  logic [ALU_LAT-1:0] vld_q;
  logic [ALU_LAT-1:0] vld_d;
  logic [CW-1:0]    inflight_q;
  logic [CW-1:0]    inflight_d;
  logic [CW-1:0]    fifo_count;
  logic [CW:0]      credits;
  alu_issue_t       iss_q;
  alu_issue_t       iss_d;

  logic accept;
  logic legal;
  logic issue;
  logic illegal;
  logic push;
  logic pop;

  assign credits  = {1'b0, inflight_q} + {1'b0, fifo_count};
  assign in_ready = !rst_q && (credits < (CW+1)'(RES_DEPTH));

  assign legal   = op_legal(in_opcode);
  assign accept  = in_valid && in_ready;
  assign issue   = accept && legal;
  assign illegal = accept && !legal;

  assign push = vld_q[ALU_LAT-1];
  assign pop  = res_valid && res_ready;

  // Next-state for the launch bundle, lane modes and shift register.
  always_comb begin
    iss_d        = iss_q;
    iss_d.opcode = in_opcode;
    iss_d.modes  = decode_modes(in_opcode);
    iss_d.din_1  = in_din_1;
    iss_d.din_2  = in_din_2;
    iss_d.din_3  = in_din_3;
    vld_d        = ALU_LAT'({vld_q, issue_q});
    inflight_d   = inflight_q + CW'(issue) - CW'(push);
  end

  // Reset shadow, issue/error pulses and in-flight tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      rst_q      <= 1'b1;
      issue_q    <= 1'b0;
      err_q      <= 1'b0;
      vld_q      <= '0;
      inflight_q <= '0;
    end else begin
      rst_q      <= 1'b0;
      issue_q    <= issue;
      err_q      <= illegal;
      vld_q      <= vld_d;
      inflight_q <= inflight_d;
    end
  end

  // ALU-facing words load on issue and hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      iss_q <= '0;
    end else if (issue) begin
      iss_q <= iss_d;
    end
  end

  assign alu_opcode  = iss_q.opcode;
  assign alu_alumode = iss_q.modes.alumode;
  assign alu_inmode  = iss_q.modes.inmode;
  assign alu_opmode  = iss_q.modes.opmode;
  assign alu_din_1   = iss_q.din_1;
  assign alu_din_2   = iss_q.din_2;
  assign alu_din_3   = iss_q.din_3;
  assign alu_cea2    = {LANES{issue_q}};
  assign alu_ceb2    = {LANES{issue_q}};
  assign alu_usemult = {LANES{issue_q}};
  assign err_illegal = err_q;

  res_fifo #(
    .DEPTH (RES_DEPTH),
    .WIDTH (WORD_WIDTH)
  ) u_res_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  (alu_dout),
    .pop_i   (pop),
    .valid_o (res_valid),
    .data_o  (res_data),
    .count_o (fifo_count)
  );

endmodule

// File: tb/tb_complex_alu_ctrl.sv
// tb_complex_alu_ctrl: randomized scoreboard bench with a
// behavioural complex ALU hanging off the DUT's ALU ports.
module tb_complex_alu_ctrl;

  localparam int ALU_LAT   = 4;
  localparam int RES_DEPTH = 8;
  localparam logic [27:0] OM_AB  = {4{7'b0000101}};
  localparam logic [27:0] OM_ACC = {7'b0110101, 7'b0000101,
                                    7'b0110101, 7'b0000101};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_opcode = 3'b000;
  logic [31:0] in_din_1 = '0;
  logic [31:0] in_din_2 = '0;
  logic [31:0] in_din_3 = '0;
  logic [2:0]  alu_opcode;
  logic [15:0] alu_alumode;
  logic [19:0] alu_inmode;
  logic [27:0] alu_opmode;
  logic [3:0]  alu_cea2;
  logic [3:0]  alu_ceb2;
  logic [3:0]  alu_usemult;
  logic [31:0] alu_din_1;
  logic [31:0] alu_din_2;
  logic [31:0] alu_din_3;
  logic [31:0] alu_dout;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] res_data;
  logic        err_illegal;

  int vectors = 0;
  int miss    = 0;
  int cyc     = 0;
  int res_cnt = 0;
  int err_cnt = 0;
  bit rr_on   = 1'b0;

  logic [31:0] exp_q[$];
  logic [31:0] alu_pipe [ALU_LAT];

  complex_alu_ctrl #(
    .ALU_LAT   (ALU_LAT),
    .RES_DEPTH (RES_DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_opcode   (in_opcode),
    .in_din_1    (in_din_1),
    .in_din_2    (in_din_2),
    .in_din_3    (in_din_3),
    .alu_opcode  (alu_opcode),
    .alu_alumode (alu_alumode),
    .alu_inmode  (alu_inmode),
    .alu_opmode  (alu_opmode),
    .alu_cea2    (alu_cea2),
    .alu_ceb2    (alu_ceb2),
    .alu_usemult (alu_usemult),
    .alu_din_1   (alu_din_1),
    .alu_din_2   (alu_din_2),
    .alu_din_3   (alu_din_3),
    .alu_dout    (alu_dout),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .err_illegal (err_illegal)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic void chk(input string name,
                              input logic [63:0] act,
                              input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic bit is_legal(input logic [2:0] op);
    return op == 3'b100 || op == 3'b101 || op == 3'b110;
  endfunction

  // Complex arithmetic on {I,Q} 16-bit signed halves.
  function automatic logic [31:0] cplx(input logic [2:0] op,
                                       input logic [31:0] a,
                                       input logic [31:0] b,
                                       input logic [31:0] c);
    int ai, aq, bi, bq, ci, cq, re, im;
    ai = int'(shortint'(a[31:16]));
    aq = int'(shortint'(a[15:0]));
    bi = int'(shortint'(b[31:16]));
    bq = int'(shortint'(b[15:0]));
    ci = int'(shortint'(c[31:16]));
    cq = int'(shortint'(c[15:0]));
    re = ai * bi - aq * bq;
    im = ai * bq + aq * bi;
    if (op == 3'b101) begin
      re = ci + re;
      im = cq + im;
    end else if (op == 3'b110) begin
      re = ci - re;
      im = cq - im;
    end
    return {re[15:0], im[15:0]};
  endfunction

  // Behavioural ALU: fixed-latency, never stalls, garbage when idle.
  always @(posedge clk) begin
    logic [31:0] r;
    r = $urandom();
    if (alu_cea2 == 4'hF && alu_ceb2 == 4'hF &&
        alu_usemult == 4'hF && alu_inmode == 20'h0) begin
      if (alu_opmode == OM_AB && alu_alumode == 16'h0000)
        r = cplx(3'b100, alu_din_1, alu_din_2, alu_din_3);
      else if (alu_opmode == OM_ACC && alu_alumode == 16'h0000)
        r = cplx(3'b101, alu_din_1, alu_din_2, alu_din_3);
      else if (alu_opmode == OM_ACC && alu_alumode == 16'h3030)
        r = cplx(3'b110, alu_din_1, alu_din_2, alu_din_3);
      else
        r = 32'hDEAD_BEEF;
    end
    alu_pipe[0] <= r;
    for (int i = 1; i < ALU_LAT; i++) alu_pipe[i] <= alu_pipe[i-1];
  end
  assign alu_dout = alu_pipe[ALU_LAT-1];

  // Monitor / scoreboard, sampled on the falling edge.
  bit          pl = 1'b0;
  bit          pi = 1'b0;
  logic [15:0] e_am = '0;
  logic [27:0] e_om = '0;
  logic [2:0]  e_opc = '0;
  logic [31:0] e_d1 = '0;
  logic [31:0] e_d2 = '0;
  logic [31:0] e_d3 = '0;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      pl = 0; pi = 0;
      e_am = '0; e_om = '0; e_opc = '0;
      e_d1 = '0; e_d2 = '0; e_d3 = '0;
    end else begin
      chk("ce_a", alu_cea2, pl ? 4'hF : 4'h0);
      chk("ce_b", alu_ceb2, pl ? 4'hF : 4'h0);
      chk("usemult", alu_usemult, pl ? 4'hF : 4'h0);
      chk("inmode", alu_inmode, 20'h0);
      chk("alumode", alu_alumode, e_am);
      chk("opmode", alu_opmode, e_om);
      chk("alu_opcode", alu_opcode, e_opc);
      chk("din_1", alu_din_1, e_d1);
      chk("din_2", alu_din_2, e_d2);
      chk("din_3", alu_din_3, e_d3);
      chk("err_pulse", err_illegal, pi);
      if (err_illegal) err_cnt++;
      if (res_valid && res_ready) begin
        res_cnt++;
        if (exp_q.size() == 0) chk("res_unexpected", res_valid, 0);
        else chk("res_data", res_data, exp_q.pop_front());
      end
      pl = in_valid && in_ready && is_legal(in_opcode);
      pi = in_valid && in_ready && !is_legal(in_opcode);
      if (pl) begin
        e_opc = in_opcode;
        e_d1 = in_din_1; e_d2 = in_din_2; e_d3 = in_din_3;
        e_om = (in_opcode == 3'b100) ? OM_AB : OM_ACC;
        e_am = (in_opcode == 3'b110) ? 16'h3030 : 16'h0000;
        exp_q.push_back(cplx(in_opcode, in_din_1, in_din_2, in_din_3));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] c,
                      output int t_acc);
    int n;
    n = 0;
    in_valid = 1'b1; in_opcode = op;
    in_din_1 = a; in_din_2 = b; in_din_3 = c;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("send_accept", in_ready, 1);
    t_acc = cyc;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    res_ready = 1'b1;
    while (exp_q.size() != 0 && n < 500) begin
      tick();
      n++;
    end
    repeat (2) tick();
    chk("drain", exp_q.size(), 0);
  endtask

  task automatic chk_reset();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_err", err_illegal, 0);
    chk("rst_opcode", alu_opcode, 0);
    chk("rst_alumode", alu_alumode, 0);
    chk("rst_inmode", alu_inmode, 0);
    chk("rst_opmode", alu_opmode, 0);
    chk("rst_ce", {alu_cea2, alu_ceb2, alu_usemult}, 0);
    chk("rst_din", {alu_din_1, alu_din_2}, 0);
    chk("rst_din_3", alu_din_3, 0);
  endtask

  function automatic logic [2:0] rand_op();
    logic [2:0] ill [5];
    int r;
    ill = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b111};
    r = $urandom_range(0, 9);
    if (r < 3) return 3'b100;
    if (r < 6) return 3'b101;
    if (r < 9) return 3'b110;
    return ill[$urandom_range(0, 4)];
  endfunction

  initial begin
    int t_acc, t_v, acc, e0, r0;

    // Reset values and in_ready release timing.
    repeat (3) tick();
    @(negedge clk);
    chk_reset();
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rel_ready_0", in_ready, 0);
    @(negedge clk);
    chk("rel_ready_1", in_ready, 1);
    tick();

    // Directed CMUL and its latency.
    res_ready = 1'b1;
    send(3'b100, 32'h0001_0002, 32'h0003_0004, 32'h0, t_acc);
    t_v = -1;
    for (int i = 0; i < 40 && t_v < 0; i++) begin
      @(negedge clk);
      if (res_valid) begin
        t_v = cyc;
        chk("cmul_data", res_data, 32'hFFFB_000A);
      end
    end
    chk("cmul_latency", t_v - t_acc, ALU_LAT + 2);
    tick();
    wait_drain();

    // Credit limit: 16 offered, RES_DEPTH accepted.
    res_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_opcode = 3'b100;
      in_din_1 = $urandom(); in_din_2 = $urandom();
      in_din_3 = $urandom();
      @(negedge clk);
      if (in_ready) acc++;
      tick();
    end
    in_valid = 1'b0;
    chk("fill_accepts", acc, RES_DEPTH);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("full_blocked", in_ready, 0);
      tick();
    end
    res_ready = 1'b1;
    @(negedge clk);
    chk("ready_in_pop_cycle", in_ready, 0);
    @(negedge clk);
    chk("ready_after_pop", in_ready, 1);
    tick();
    wait_drain();

    // Illegal opcode between two MULADDs.
    e0 = err_cnt; r0 = res_cnt;
    send(3'b101, $urandom(), $urandom(), $urandom(), t_acc);
    send(3'b011, $urandom(), $urandom(), $urandom(), t_acc);
    send(3'b101, $urandom(), $urandom(), $urandom(), t_acc);
    wait_drain();
    chk("illegal_pulses", err_cnt - e0, 1);
    chk("illegal_results", res_cnt - r0, 2);

    // MULSUB lane modes and single-cycle CE.
    send(3'b110, 32'h0005_FFFE, 32'h0002_0003, 32'h0100_0200, t_acc);
    @(negedge clk);
    chk("msub_alumode", alu_alumode, 16'h3030);
    chk("msub_opmode", alu_opmode, OM_ACC);
    chk("msub_ce", alu_cea2, 4'hF);
    @(negedge clk);
    chk("msub_ce_once", alu_cea2, 4'h0);
    tick();
    wait_drain();

    // Back-to-back stream with res_ready high: push+pop at count 1.
    for (int i = 0; i < 6; i++)
      send(3'b100, $urandom(), $urandom(), $urandom(), t_acc);
    wait_drain();

    // Randomized traffic with random backpressure.
    rr_on = 1'b1;
    fork
      begin
        while (rr_on) begin
          tick();
          res_ready = ($urandom_range(0, 2) != 0);
        end
      end
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 3) != 0)
            send(rand_op(), $urandom(), $urandom(), $urandom(), t_acc);
          else
            tick();
        end
        rr_on = 1'b0;
      end
    join
    wait_drain();

    // Reset with 2 results queued and 3 in flight.
    res_ready = 1'b0;
    send(3'b100, $urandom(), $urandom(), $urandom(), t_acc);
    send(3'b101, $urandom(), $urandom(), $urandom(), t_acc);
    repeat (ALU_LAT + 4) tick();
    @(negedge clk);
    chk("pre_rst_fifo", res_valid, 1);
    tick();
    send(3'b100, $urandom(), $urandom(), $urandom(), t_acc);
    send(3'b110, $urandom(), $urandom(), $urandom(), t_acc);
    send(3'b101, $urandom(), $urandom(), $urandom(), t_acc);
    rst = 1'b1;
    @(negedge clk);
    tick();
    @(negedge clk);
    chk_reset();
    tick();
    tick();
    rst = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    chk("rst_rel_ready_0", in_ready, 0);
    @(negedge clk);
    chk("rst_rel_ready_1", in_ready, 1);
    for (int i = 0; i < ALU_LAT + 6; i++) begin
      @(negedge clk);
      chk("no_stale_result", res_valid, 0);
    end
    tick();
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
    $finish;
  end

endmodule
